// File: rtl/intr_stack_seq_pkg.sv
// ============================================================================
// Module : cpu_pkg
// Brief  : Shared encodings and output decode for the interrupt stack sequencer
// Rev    : 1.0
// ============================================================================
`default_nettype none

package cpu_pkg;

    localparam logic [3:0] c_stk_none     = 4'b0000;
    localparam logic [3:0] c_stk_pop      = 4'b0101;
    localparam logic [3:0] c_stk_push_pc  = 4'b0110;
    localparam logic [3:0] c_stk_push_ccr = 4'b0111;

    localparam logic [1:0] c_pc_none  = 2'b00;
    localparam logic [1:0] c_pc_vec   = 2'b01;
    localparam logic [1:0] c_pc_stack = 2'b10;

    localparam logic [7:0] c_sp_floor = 8'd200;
    localparam logic [7:0] c_sp_ceil  = 8'd255;
    localparam logic [7:0] c_vec_addr = 8'h01;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        I_PC  = 3'd1,
        I_CCR = 3'd2,
        I_VEC = 3'd3,
        R_POP = 3'd4
    } state_t;

    typedef struct packed {
        logic       mem_en;
        logic       mem_write;
        logic       mem_read;
        logic [3:0] stack_ctrl;
        logic       stack_push;
        logic       stack_pop;
        logic       pc_load;
        logic [1:0] pc_src;
        logic       ccr_load;
        logic       freeze;
        logic       intr_ack;
    } ctrl_t;

    // Moore decode: control word that belongs to a given state.
    function automatic ctrl_t f_decode(input state_t s);
        ctrl_t c;
        c            = '0;
        c.stack_ctrl = c_stk_none;
        c.pc_src     = c_pc_none;
        case (s)
            I_PC: begin
                c.mem_en     = 1'b1;
                c.mem_write  = 1'b1;
                c.stack_ctrl = c_stk_push_pc;
                c.stack_push = 1'b1;
                c.freeze     = 1'b1;
            end
            I_CCR: begin
                c.mem_en     = 1'b1;
                c.mem_write  = 1'b1;
                c.stack_ctrl = c_stk_push_ccr;
                c.freeze     = 1'b1;
            end
            I_VEC: begin
                c.pc_load  = 1'b1;
                c.pc_src   = c_pc_vec;
                c.intr_ack = 1'b1;
                c.freeze   = 1'b1;
            end
            R_POP: begin
                c.mem_en     = 1'b1;
                c.mem_read   = 1'b1;
                c.stack_ctrl = c_stk_pop;
                c.stack_pop  = 1'b1;
                c.pc_load    = 1'b1;
                c.pc_src     = c_pc_stack;
                c.ccr_load   = 1'b1;
                c.freeze     = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

`default_nettype wire

// File: rtl/intr_stack_seq_if.sv
// ============================================================================
// Module : intr_stack_seq_if
// Brief  : CU / stack-stage signal bundle of the interrupt stack sequencer
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface intr_stack_seq_if;
    logic       intr_in;
    logic       instr_boundary;
    logic       rti_req;
    logic [7:0] sp;
    logic       mem_en;
    logic       mem_write;
    logic       mem_read;
    logic [3:0] stack_ctrl;
    logic       stack_push;
    logic       stack_pop;
    logic       pc_load;
    logic [1:0] pc_src;
    logic [7:0] vec_addr;
    logic       ccr_load;
    logic       freeze;
    logic       intr_ack;
    logic       in_isr;
    logic       stack_err;
    logic       rti_err;

    modport master (
        output intr_in, instr_boundary, rti_req, sp,
        input  mem_en, mem_write, mem_read, stack_ctrl, stack_push, stack_pop,
               pc_load, pc_src, vec_addr, ccr_load, freeze, intr_ack, in_isr,
               stack_err, rti_err
    );

    modport slave (
        input  intr_in, instr_boundary, rti_req, sp,
        output mem_en, mem_write, mem_read, stack_ctrl, stack_push, stack_pop,
               pc_load, pc_src, vec_addr, ccr_load, freeze, intr_ack, in_isr,
               stack_err, rti_err
    );
endinterface

`default_nettype wire

// File: rtl/intr_sync.sv
// ============================================================================
// Module : intr_sync
// Brief  : Two-flop synchronizer and rising-edge detector for the interrupt pin
// Rev    : 1.0
// ============================================================================
`default_nettype none

module intr_sync (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_intr,
    output logic      o_rise
);

    logic r_meta;
    logic r_sync;
    logic r_sync_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta   <= 1'b0;
            r_sync   <= 1'b0;
            r_sync_d <= 1'b0;
        end else begin
            r_meta   <= i_intr;
            r_sync   <= r_meta;
            r_sync_d <= r_sync;
        end
    end

    assign o_rise = r_sync & ~r_sync_d;

endmodule

`default_nettype wire

// File: rtl/intr_stack_seq.sv
// ============================================================================
// Module : intr_stack_seq
// Brief  : Interrupt entry (push PC/CCR, vector) and RTI (pop) sequencer
// Rev    : 1.0
// ============================================================================
`default_nettype none

module intr_stack_seq
    import cpu_pkg::*;
(
    input  wire logic        clk,
    input  wire logic        rst,
    intr_stack_seq_if.slave  bus
);

    state_t r_state;
    state_t w_next;
    ctrl_t  r_ctrl;
    logic   r_pending;
    logic   r_in_isr;
    logic   r_stack_err;
    logic   r_rti_err;
    logic   w_rise;
    logic   w_take_rti;
    logic   w_take_intr;

    intr_sync u_sync (
        .clk    (clk),
        .rst    (rst),
        .i_intr (bus.intr_in),
        .o_rise (w_rise)
    );

    // RTI has priority; an interrupt is only eligible outside the handler.
    assign w_take_rti  = (r_state == IDLE) && bus.rti_req && r_in_isr;
    assign w_take_intr = (r_state == IDLE) && bus.instr_boundary && r_pending && !r_in_isr;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_take_rti)
                    w_next = R_POP;
                else if (w_take_intr)
                    w_next = I_PC;
            end
            I_PC:    w_next = I_CCR;
            I_CCR:   w_next = I_VEC;
            I_VEC:   w_next = IDLE;
            R_POP:   w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Control word is registered together with the state it belongs to.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_ctrl      <= '0;
            r_pending   <= 1'b0;
            r_in_isr    <= 1'b0;
            r_stack_err <= 1'b0;
            r_rti_err   <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_ctrl    <= f_decode(w_next);
            r_pending <= w_rise | (r_pending & (r_state != I_VEC));
            if (r_state == I_VEC)
                r_in_isr <= 1'b1;
            else if (r_state == R_POP)
                r_in_isr <= 1'b0;
            if (((r_state == I_PC) && (bus.sp == c_sp_floor)) ||
                ((r_state == R_POP) && (bus.sp == c_sp_ceil)))
                r_stack_err <= 1'b1;
            if (bus.rti_req && !r_in_isr)
                r_rti_err <= 1'b1;
        end
    end

    assign bus.mem_en     = r_ctrl.mem_en;
    assign bus.mem_write  = r_ctrl.mem_write;
    assign bus.mem_read   = r_ctrl.mem_read;
    assign bus.stack_ctrl = r_ctrl.stack_ctrl;
    assign bus.stack_push = r_ctrl.stack_push;
    assign bus.stack_pop  = r_ctrl.stack_pop;
    assign bus.pc_load    = r_ctrl.pc_load;
    assign bus.pc_src     = r_ctrl.pc_src;
    assign bus.ccr_load   = r_ctrl.ccr_load;
    assign bus.freeze     = r_ctrl.freeze;
    assign bus.intr_ack   = r_ctrl.intr_ack;
    assign bus.vec_addr   = c_vec_addr;
    assign bus.in_isr     = r_in_isr;
    assign bus.stack_err  = r_stack_err;
    assign bus.rti_err    = r_rti_err;

endmodule

`default_nettype wire

// File: tb/tb_intr_stack_seq.sv
// ============================================================================
// Module : tb_intr_stack_seq
// Brief  : Self-checking bench for intr_stack_seq with a behavioural model
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_intr_stack_seq;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    intr_stack_seq_if bus();

    intr_stack_seq dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;
    int acks   = 0;
    logic [15:0] g_pack;

    // Behavioural model state: entry step 0 (none) / 1..3, pop cycle flag.
    bit q[$];
    bit m_pend, m_isr, m_serr, m_rerr, m_pop;
    int m_entry;

    typedef struct packed {
        bit          i;
        bit          b;
        bit          r;
        logic [7:0]  sp;
        logic [15:0] exp;
    } vec_t;
    vec_t tbl [0:9];

    function automatic logic [15:0] dut_pack();
        return {bus.mem_en, bus.mem_write, bus.mem_read, bus.stack_ctrl,
                bus.stack_push, bus.stack_pop, bus.pc_load, bus.pc_src,
                bus.ccr_load, bus.freeze, bus.intr_ack, bus.in_isr};
    endfunction

    function automatic logic [15:0] model_pack();
        logic [3:0] sc;
        logic [1:0] ps;
        sc = (m_entry == 1) ? 4'b0110 : (m_entry == 2) ? 4'b0111 : m_pop ? 4'b0101 : 4'b0000;
        ps = (m_entry == 3) ? 2'b01 : m_pop ? 2'b10 : 2'b00;
        return {(m_entry == 1 || m_entry == 2 || m_pop), (m_entry == 1 || m_entry == 2), m_pop,
                sc, (m_entry == 1), m_pop, (m_entry == 3 || m_pop), ps, m_pop,
                (m_entry != 0 || m_pop), (m_entry == 3), m_isr};
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        repeat (4) q.push_back(1'b0);
        m_pend = 0; m_isr = 0; m_serr = 0; m_rerr = 0; m_pop = 0; m_entry = 0;
    endtask

    task automatic model_update(input bit i, input bit b, input bit r, input logic [7:0] s);
        bit rise, new_pend;
        q.push_back(i);
        rise = q[$-2] && !q[$-3];
        void'(q.pop_front());
        if ((m_entry == 1 && s == 8'd200) || (m_pop && s == 8'd255)) m_serr = 1;
        if (r && !m_isr) m_rerr = 1;
        new_pend = rise || (m_pend && m_entry != 3);
        if (m_entry == 3) begin
            m_isr = 1; m_entry = 0;
        end else if (m_entry != 0) begin
            m_entry++;
        end else if (m_pop) begin
            m_isr = 0; m_pop = 0;
        end else if (r && m_isr) begin
            m_pop = 1;
        end else if (b && m_pend && !m_isr) begin
            m_entry = 1;
        end
        m_pend = new_pend;
    endtask

    task automatic check_model();
        check("ctrl", dut_pack(), model_pack());
        check("status", {6'b0, bus.vec_addr, bus.stack_err, bus.rti_err},
              {6'b0, 8'h01, m_serr, m_rerr});
    endtask

    task automatic step(input bit i, input bit b, input bit r, input logic [7:0] s);
        bus.intr_in = i; bus.instr_boundary = b; bus.rti_req = r; bus.sp = s;
        @(negedge clk);
        check_model();
        g_pack = dut_pack();
        if (bus.intr_ack) acks++;
        @(posedge clk);
        model_update(i, b, r, s);
        #1;
    endtask

    task automatic enter(input logic [7:0] s);
        step(1, 0, 0, s); step(0, 0, 0, s); step(0, 0, 0, s); step(0, 1, 0, s);
        repeat (3) step(0, 0, 0, s);
    endtask

    initial begin
        bit lvl;
        int k;
        tbl[0] = '{1'b1, 1'b0, 1'b0, 8'd250, 16'h0000};
        tbl[1] = '{1'b0, 1'b0, 1'b0, 8'd250, 16'h0000};
        tbl[2] = '{1'b0, 1'b0, 1'b0, 8'd250, 16'h0000};
        tbl[3] = '{1'b0, 1'b1, 1'b0, 8'd250, 16'h0000};
        tbl[4] = '{1'b0, 1'b0, 1'b0, 8'd250, 16'hCD04};
        tbl[5] = '{1'b0, 1'b0, 1'b0, 8'd250, 16'hCE04};
        tbl[6] = '{1'b0, 1'b0, 1'b0, 8'd250, 16'h0056};
        tbl[7] = '{1'b0, 1'b0, 1'b1, 8'd248, 16'h0001};
        tbl[8] = '{1'b0, 1'b0, 1'b0, 8'd248, 16'hAAED};
        tbl[9] = '{1'b0, 1'b0, 1'b0, 8'd248, 16'h0000};

        rst = 1'b1;
        bus.intr_in = 0; bus.instr_boundary = 0; bus.rti_req = 0; bus.sp = 8'd250;
        repeat (2) @(posedge clk);
        #1;
        check("reset_ctrl", dut_pack(), 16'h0000);
        check("reset_status", {6'b0, bus.vec_addr, bus.stack_err, bus.rti_err}, 16'h0004);
        model_reset();
        rst = 1'b0;

        // Entry then RTI, expected words written out per cycle.
        for (int n = 0; n < 10; n++) begin
            bus.intr_in = tbl[n].i; bus.instr_boundary = tbl[n].b;
            bus.rti_req = tbl[n].r; bus.sp = tbl[n].sp;
            @(negedge clk);
            check($sformatf("vec_row%0d", n), dut_pack(), tbl[n].exp);
            check_model();
            @(posedge clk);
            model_update(tbl[n].i, tbl[n].b, tbl[n].r, tbl[n].sp);
            #1;
        end

        // Two edges inside the handler collapse into one entry after RTI.
        enter(8'd250);
        acks = 0;
        step(1, 0, 0, 250); step(0, 0, 0, 250); step(0, 0, 0, 250);
        step(1, 0, 0, 250); repeat (3) step(0, 0, 0, 250);
        step(0, 1, 0, 250); step(0, 1, 0, 250);
        step(0, 0, 1, 248); step(0, 0, 0, 248);
        step(0, 1, 0, 248); repeat (4) step(0, 0, 0, 248);
        step(0, 0, 1, 248); step(0, 0, 0, 248);
        step(0, 1, 0, 248); repeat (4) step(0, 0, 0, 248);
        check("single_entry", 16'(acks), 16'd1);

        // RTI and pending interrupt on the same boundary: pop first.
        enter(8'd250);
        step(1, 0, 0, 250); repeat (3) step(0, 0, 0, 250);
        step(0, 1, 1, 248);
        step(0, 0, 0, 248);
        check("rti_first", g_pack, 16'hAAED);
        step(0, 1, 0, 248);
        repeat (3) step(0, 0, 0, 248);
        check("entry_after_rti", g_pack, 16'h0056);
        step(0, 0, 0, 248);
        step(0, 0, 1, 248); step(0, 0, 0, 248);

        // Push at SP floor, then RTI outside the handler.
        enter(8'd200);
        step(0, 0, 0, 200);
        check("stack_err_floor", 16'(bus.stack_err), 16'd1);
        check("floor_isr", 16'(bus.in_isr), 16'd1);
        step(0, 0, 1, 200); step(0, 0, 0, 200); step(0, 0, 0, 200);
        check("stack_err_sticky", 16'(bus.stack_err), 16'd1);
        step(0, 0, 1, 200);
        step(0, 0, 0, 200);
        check("rti_ignored", g_pack, 16'h0000);
        check("rti_err", 16'(bus.rti_err), 16'd1);

        // Asynchronous reset while in I_CCR.
        step(1, 0, 0, 250); step(0, 0, 0, 250); step(0, 0, 0, 250);
        step(0, 1, 0, 250); step(0, 0, 0, 250);
        check("in_ccr", dut_pack(), 16'hCE04);
        rst = 1'b1;
        #1;
        check("rst_async", dut_pack(), 16'h0000);
        check("rst_status", {6'b0, bus.vec_addr, bus.stack_err, bus.rti_err}, 16'h0004);
        model_reset();
        @(negedge clk);
        check("rst_no_write", 16'(bus.mem_write), 16'd0);
        @(posedge clk);
        #1;
        check("rst_idle", dut_pack(), 16'h0000);
        rst = 1'b0;

        // Pop at SP ceiling.
        enter(8'd250);
        step(0, 0, 1, 255); step(0, 0, 0, 255); step(0, 0, 0, 255);
        check("stack_err_ceiling", 16'(bus.stack_err), 16'd1);

        // Randomized traffic against the model.
        lvl = 0;
        for (int n = 0; n < 400; n++) begin
            logic [7:0] s;
            if ($urandom_range(0, 5) == 0) lvl = ~lvl;
            k = $urandom_range(0, 3);
            s = (k == 0) ? 8'd200 : (k == 1) ? 8'd255 : 8'($urandom_range(0, 255));
            step(lvl, ($urandom_range(0, 2) == 0), ($urandom_range(0, 5) == 0), s);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
